fir_stream_driver: RTL and testbench
====================================

Name: fir_stream_driver

Overview:
- Transmit side of the single-tap FIR pin interface: generates the FIR's 8-bit io_in bus (FIR clock on bit 0, FIR reset on bit 1, sign-magnitude sample on bits 7:2) and captures the FIR's 8-bit io_out.
- Buffers two's-complement samples from an upstream valid/ready stream and converts them to sign-magnitude.
- Per session: sequences FIR reset, coefficient load and sample streaming, then returns each FIR result on a strobed output.

Parameters:
- BW_in, 6, FIR sample width: 1 sign bit + (BW_in-1) magnitude bits; also width of s_data and coef_in.
- FIFO_DEPTH, 4, sample FIFO entries; power of two, at least 2.
- RESET_CYCLES, 2, number of FIR clock periods with FIR reset held high; at least 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a session. Ignored unless in IDLE.
- stop  in  1  one-cycle pulse; ends the session once the FIFO has drained.
- coef_in  in  BW_in  two's-complement coefficient, latched on an accepted start.
- s_data  in  BW_in  two's-complement sample.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  FIFO can accept.
- fir_io  out  8  drives FIR io_in; [0]=FIR clk, [1]=FIR reset, [7:2]=sign-magnitude x.
- fir_out  in  8  FIR io_out (combinational from FIR state).
- m_data  out  8  captured FIR result.
- m_valid  out  1  one-cycle strobe; no backpressure.
- busy  out  1  high in any state except IDLE.
- sat_seen  out  1  sticky; cleared on accepted start.

Behaviour:
- Reset (async, reset_n=0) forces the following, and applies mid-operation too, discarding any partially sent sample:
  - fir_io=8'h02 (FIR reset high, FIR clk low).
  - m_data=0, m_valid=0, busy=0, sat_seen=0, s_ready=0.
  - FIFO flushed, state=IDLE.
- All outputs are registered except s_ready, which is combinational from state and FIFO count.
- Encoding, enc(v):
  - sign = v[BW_in-1]; mag = |v|.
  - The most negative value (-32 at default) saturates to mag 2^(BW_in-1)-1 and sets sat_seen.
  - 0 encodes as sign 0.
  - fir_io[7:2] = {sign, mag}.
- FIFO:
  - s_ready = (state != IDLE) && count < FIFO_DEPTH.
  - Push on s_valid && s_ready. There is no bypass, so a write becomes visible to pop on the next cycle.
  - Simultaneous push and pop are legal; count is unchanged.
  - A push while full cannot occur, because s_ready is low.
- States and transitions:
  - IDLE: fir_io holds its last value with bit0=0. On start: latch coef_in, clear sat_seen, go to RST.
  - RST: RESET_CYCLES periods of {low cycle, high cycle} on fir_io[0], with fir_io[1]=1 and fir_io[7:2]=0. Then go to COEF.
  - COEF: low cycle with fir_io = {enc(coef), 1'b0, 1'b0}, then high cycle with bit0=1 (the FIR loads the coefficient on this edge). Then go to STREAM.
  - STREAM: 3-phase loop.
    - ph0 low: if the FIFO is non-empty, pop, drive fir_io = {enc(head), 0, 0}, go to ph1; otherwise hold fir_io[0]=0 and stay in ph0.
    - ph1 high: fir_io[0]=1 (the FIR latches x on this edge).
    - ph2 capture: m_data <= fir_out, m_valid <= 1, fir_io[0] <= 0, go to ph0.
- Throughput and latency:
  - Throughput is one sample per 3 clocks.
  - Latency: with the FIFO empty in STREAM ph0, a sample accepted on edge t gives m_valid high in the cycle after edge t+3.
- stop:
  - stop is registered as pending; it is ignored in IDLE.
  - When pending and in STREAM ph0 with the FIFO empty, go to IDLE and clear pending.
  - A stop during RST or COEF is honoured after COEF completes and the FIFO drains.
- fir_io[1] is 0 in COEF and STREAM. The FIR clock never has two rising edges within 2 clocks.
- Simultaneous start and stop in IDLE: start wins, and stop is discarded.

Test Plan:
- Reset and idle: hold reset_n=0 -> fir_io=0x02, all other outputs 0. Release reset with no start -> busy=0, s_ready=0, fir_io bit0 never toggles.
- Session bring-up: start with coef_in=3, RESET_CYCLES=2 -> fir_io sequence 0x02,0x03,0x02,0x03, then 0x0C,0x0D. busy=1 throughout.
- Sample path against a FIR model: coef 3, sample -5 -> fir_io 0x94 then 0x95, m_data=0xF1 (-15). Sample 7 with coef 3 -> m_data=0x15 (21).
- Saturation: sample -32 -> fir_io[7:2]=0x3F, sat_seen=1 until the next start. Sample 0 -> fir_io[7:2]=0x00.
- Backpressure and FIFO: hold s_valid=1 for 10 samples -> s_ready drops at count 4. All 10 m_valid strobes arrive in order, spaced 3 clocks apart.
- Stop and mid-operation reset:
  - stop with 2 samples queued -> both results are emitted, then busy=0.
  - reset_n low during STREAM ph1 -> immediate fir_io=0x02, FIFO empty, no further m_valid.

Source files
------------

// File: rtl/fir_stream_driver.sv
// fir_stream_driver: buffers two's-complement samples, sequences FIR reset/coefficient
// load/sample streaming over the FIR's 8-bit pin bus, and returns each FIR result.
module fir_stream_driver #(
  parameter int BW_in        = 6,
  parameter int FIFO_DEPTH   = 4,
  parameter int RESET_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic [BW_in-1:0] coef_in,
  input  logic [BW_in-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [7:0]       fir_io,
  input  logic [7:0]       fir_out,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             busy,
  output logic             sat_seen
);

  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RST, S_COEF, S_STREAM} state_t;
  typedef enum logic [1:0] {PH_LO, PH_HI, PH_CAP} phase_t;

  state_t         state, state_nx;
  phase_t         ph, ph_nx;
  logic [RCW-1:0] rcnt, rcnt_nx;
  logic           stop_pend;
  logic [BW_in-1:0] coef_q, coef_nx;

  logic [BW_in-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             fifo_empty, push, pop, accept_start, drain_exit;

  logic [7:0]     fir_io_nx, m_data_nx;
  logic           m_valid_nx, sat_nx;
  logic [BW_in:0] coef_enc, head_enc;

  // Returns {saturated, sign, magnitude}; the most negative input clamps to the largest magnitude.
  function automatic logic [BW_in:0] enc(input logic [BW_in-1:0] v);
    logic [BW_in-1:0] neg;
    neg = '0 - v;
    if (v == {1'b1, {(BW_in-1){1'b0}}})
      enc = {2'b11, {(BW_in-1){1'b1}}};
    else if (v[BW_in-1])
      enc = {2'b01, neg[BW_in-2:0]};
    else
      enc = {2'b00, v[BW_in-2:0]};
  endfunction

  function automatic logic [7:0] pins(input logic [BW_in:0] e);
    pins = {6'(e[BW_in-1:0]), 2'b00};
  endfunction

  assign fifo_empty   = (count == '0);
  assign s_ready      = (state != S_IDLE) && (count < CW'(FIFO_DEPTH));
  assign push         = s_valid && s_ready;
  assign accept_start = (state == S_IDLE) && start;
  assign head_enc     = enc(mem[rd_ptr]);
  assign coef_enc     = enc(coef_q);
  assign drain_exit   = (state == S_STREAM) && (ph == PH_LO) && fifo_empty && stop_pend;

  // State register; a stop is remembered until the stream drains, and dropped in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      ph        <= PH_LO;
      rcnt      <= '0;
      stop_pend <= 1'b0;
    end else begin
      state <= state_nx;
      ph    <= ph_nx;
      rcnt  <= rcnt_nx;
      if (state == S_IDLE || drain_exit)
        stop_pend <= 1'b0;
      else if (stop)
        stop_pend <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    ph_nx    = ph;
    rcnt_nx  = rcnt;
    pop      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_RST;
          ph_nx    = PH_HI;
          rcnt_nx  = '0;
        end
      end
      S_RST: begin
        if (ph == PH_LO) begin
          ph_nx = PH_HI;
        end else begin
          ph_nx = PH_LO;
          if (rcnt == RCW'(RESET_CYCLES - 1))
            state_nx = S_COEF;
          else
            rcnt_nx = rcnt + RCW'(1);
        end
      end
      S_COEF: begin
        if (ph == PH_LO) begin
          ph_nx = PH_HI;
        end else begin
          state_nx = S_STREAM;
          ph_nx    = PH_LO;
        end
      end
      S_STREAM: begin
        case (ph)
          PH_LO: begin
            if (!fifo_empty) begin
              pop   = 1'b1;
              ph_nx = PH_HI;
            end else if (stop_pend) begin
              state_nx = S_IDLE;
            end
          end
          PH_HI:   ph_nx = PH_CAP;
          default: ph_nx = PH_LO;
        endcase
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; the start edge already shows the first reset-low cycle.
  always_comb begin
    fir_io_nx  = fir_io;
    m_data_nx  = m_data;
    m_valid_nx = 1'b0;
    sat_nx     = sat_seen;
    coef_nx    = coef_q;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          coef_nx   = coef_in;
          sat_nx    = 1'b0;
          fir_io_nx = 8'h02;
        end
      end
      S_RST: begin
        fir_io_nx = (ph == PH_LO) ? 8'h02 : 8'h03;
      end
      S_COEF: begin
        if (ph == PH_LO) begin
          fir_io_nx = pins(coef_enc);
          sat_nx    = sat_seen | coef_enc[BW_in];
        end else begin
          fir_io_nx[0] = 1'b1;
        end
      end
      S_STREAM: begin
        case (ph)
          PH_LO: begin
            if (!fifo_empty) begin
              fir_io_nx = pins(head_enc);
              sat_nx    = sat_seen | head_enc[BW_in];
            end else begin
              fir_io_nx[0] = 1'b0;
            end
          end
          PH_HI: fir_io_nx[0] = 1'b1;
          default: begin
            m_data_nx    = fir_out;
            m_valid_nx   = 1'b1;
            fir_io_nx[0] = 1'b0;
          end
        endcase
      end
      default: fir_io_nx = 8'h02;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fir_io   <= 8'h02;
      m_data   <= '0;
      m_valid  <= 1'b0;
      busy     <= 1'b0;
      sat_seen <= 1'b0;
      coef_q   <= '0;
    end else begin
      fir_io   <= fir_io_nx;
      m_data   <= m_data_nx;
      m_valid  <= m_valid_nx;
      busy     <= (state_nx != S_IDLE);
      sat_seen <= sat_nx;
      coef_q   <= coef_nx;
    end
  end

  // A push on the session-ending edge would otherwise linger into the next session.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (accept_start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

endmodule

// File: tb/tb_fir_stream_driver.sv
// Bench for fir_stream_driver: a behavioural single-tap FIR on the pin bus plus an
// arithmetic scoreboard of expected products, driven by directed and random steps.
module tb_fir_stream_driver;

  logic       clk = 1'b0;
  logic       reset_n, start, stop, s_valid;
  logic [5:0] coef_in, s_data;
  logic       s_ready, m_valid, busy, sat_seen;
  logic [7:0] fir_io, fir_out, m_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_rise = -100;
  logic prev0 = 1'b0;
  logic [5:0] coef_cur = 6'd3;
  logic [7:0] exp_q[$];
  int mv_cyc[$];

  fir_stream_driver #(.BW_in(6), .FIFO_DEPTH(4), .RESET_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .coef_in(coef_in),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .fir_io(fir_io),
    .fir_out(fir_out), .m_data(m_data), .m_valid(m_valid), .busy(busy), .sat_seen(sat_seen)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int smdec(input logic [5:0] s);
    return s[5] ? -int'(s[4:0]) : int'(s[4:0]);
  endfunction

  function automatic logic [5:0] enc6(input logic [5:0] v);
    int i;
    i = $signed(v);
    if (i == -32) return 6'h3F;
    if (i < 0) return {1'b1, 5'(-i)};
    return {1'b0, 5'(i)};
  endfunction

  function automatic logic [7:0] exp_prod(input logic [5:0] c, input logic [5:0] x);
    int ci, xi;
    ci = $signed(c);
    xi = $signed(x);
    if (ci == -32) ci = -31;
    if (xi == -32) xi = -31;
    return 8'(ci * xi);
  endfunction

  // External single-tap FIR: first rising edge after reset loads the coefficient.
  logic [7:0] fir_y = 8'h00;
  logic       fir_loaded = 1'b0;
  int         fir_c = 0;
  always @(posedge fir_io[0]) begin
    if (fir_io[1]) begin
      fir_y = 8'h00;
      fir_loaded = 1'b0;
    end else if (!fir_loaded) begin
      fir_c = smdec(fir_io[7:2]);
      fir_loaded = 1'b1;
    end else begin
      fir_y = 8'(fir_c * smdec(fir_io[7:2]));
    end
  end
  assign fir_out = fir_y;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (s_valid && s_ready) exp_q.push_back(exp_prod(coef_cur, s_data));
      if (m_valid) begin
        mv_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("m_valid_unexpected", 32'(m_valid), 0);
        else chk("m_data", m_data, exp_q.pop_front());
      end
      if (fir_io[0] && !prev0) begin
        chk("fir_clk_gap", 32'((cyc - last_rise) >= 2), 1);
        last_rise = cyc;
      end
    end
    prev0 = fir_io[0];
  end

  task automatic start_session(input logic [5:0] c, input logic with_stop);
    @(posedge clk); #1;
    start = 1'b1; stop = with_stop; coef_in = c; coef_cur = c;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic bringup(input logic [5:0] c);
    logic [7:0] seq [6];
    seq = '{8'h02, 8'h03, 8'h02, 8'h03, {enc6(c), 2'b00}, {enc6(c), 2'b01}};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bringup_io", fir_io, seq[i]);
      chk("bringup_busy", busy, 1);
      if (i == 0) chk("start_clears_sat", sat_seen, 0);
    end
  endtask

  // Precondition: STREAM ph0 with an empty FIFO at the next edge.
  task automatic send_dir(input logic [5:0] v, input logic [7:0] io_lo);
    @(posedge clk); #1; s_valid = 1'b1; s_data = v;
    @(posedge clk); #1; s_valid = 1'b0;
    @(negedge clk); chk("dir_io_wait", fir_io[0], 0);
    @(negedge clk); chk("dir_io_lo", fir_io, io_lo);
    @(negedge clk); chk("dir_io_hi", fir_io, io_lo | 8'h01);
    @(negedge clk); chk("dir_mvalid", m_valid, 1); chk("dir_mdata", m_data, exp_prod(coef_cur, v));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    int acc, pops, base;
    logic rdy, saw_low;
    logic [5:0] c2;
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; coef_in = '0; s_data = '0; s_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_fir_io", fir_io, 8'h02);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat", sat_seen, 0);
    chk("rst_s_ready", s_ready, 0);
    @(posedge clk); #1; reset_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_s_ready", s_ready, 0);
      chk("idle_fir_io", fir_io, 8'h02);
    end

    start_session(6'd3, 1'b0);
    bringup(6'd3);
    send_dir(6'h3B, 8'h94);
    send_dir(6'd7, 8'h1C);
    send_dir(6'h20, 8'hFC);
    chk("sat_after_min", sat_seen, 1);
    send_dir(6'd0, 8'h00);
    chk("sat_sticky", sat_seen, 1);

    // Continuous offer of 10 samples: pops land one edge after the first push, then every 3.
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 6'($urandom); acc = 0; saw_low = 1'b0; base = mv_cyc.size();
    rdy = s_ready;
    for (int k = 0; acc < 10 && k < 100; k++) begin
      @(posedge clk); #1;
      if (rdy) begin
        acc++;
        if (acc < 10) s_data = 6'($urandom); else s_valid = 1'b0;
      end
      @(negedge clk);
      pops = (k == 0) ? 0 : (k - 1) / 3 + 1;
      chk("bp_s_ready", s_ready, 32'((acc - pops) < 4));
      if (!s_ready) saw_low = 1'b1;
      rdy = s_ready;
    end
    s_valid = 1'b0;
    chk("bp_saw_low", saw_low, 1);
    drain("bp_drain");
    chk("bp_count", mv_cyc.size() - base, 10);
    if (mv_cyc.size() - base == 10)
      for (int i = 1; i < 10; i++) chk("bp_spacing", mv_cyc[base+i] - mv_cyc[base+i-1], 3);

    base = mv_cyc.size();
    @(posedge clk); #1; s_valid = 1'b1; s_data = 6'($urandom);
    @(posedge clk); #1; s_data = 6'($urandom);
    @(posedge clk); #1; s_valid = 1'b0; stop = 1'b1;
    @(posedge clk); #1; stop = 1'b0;
    for (int i = 0; i < 40 && busy !== 1'b0; i++) begin
      @(negedge clk); #1;
    end
    chk("stop_busy", busy, 0);
    chk("stop_results", mv_cyc.size() - base, 2);
    chk("stop_s_ready", s_ready, 0);
    chk("stop_clk_low", fir_io[0], 0);

    c2 = 6'($urandom);
    start_session(c2, 1'b1);
    bringup(c2);
    chk("sat_coef", sat_seen, 32'(c2 == 6'h20));
    repeat (6) @(negedge clk);
    chk("start_wins_busy", busy, 1);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      s_valid = 1'($urandom_range(0, 1));
      s_data = 6'($urandom);
    end
    @(posedge clk); #1; s_valid = 1'b0;
    drain("rand_drain");

    @(posedge clk); #1; s_valid = 1'b1; s_data = 6'($urandom);
    @(posedge clk); #1; s_valid = 1'b0;
    for (int i = 0; i < 12 && fir_io[0] !== 1'b1; i++) @(negedge clk);
    chk("ph1_reached", fir_io[0], 1);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_fir_io", fir_io, 8'h02);
    chk("midrst_busy", busy, 0);
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_m_data", m_data, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_fir_io", fir_io, 8'h02);
      chk("post_rst_busy", busy, 0);
    end

    start_session(6'd3, 1'b0);
    bringup(6'd3);
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_empty", fir_io, 8'h0C);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "bench timeout");
  end

endmodule
